// File: rtl/key_pkg.sv
// Shared constants and counter types for the pushbutton conditioning block.
package key_pkg;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned REPEAT_DELAY  = 25000000;
  localparam int unsigned REPEAT_PERIOD = 5000000;

  localparam int unsigned KEY_CNT_W = $clog2(DEBOUNCE_CYCLES_DEFAULT);
  localparam int unsigned KEY_RPT_W = $clog2(REPEAT_DELAY);

  typedef logic [KEY_CNT_W-1:0] key_cnt_t;
  typedef logic [KEY_RPT_W-1:0] key_rpt_cnt_t;
endpackage

// File: rtl/key_debounce_chan.sv
// Single key: 2-flop synchroniser, debounce counter, level and press/release strobes.
// Optional auto-repeat of the press strobe under KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_chan
  import key_pkg::*;
#(
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY    = key_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = key_pkg::REPEAT_PERIOD,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_sync;
  logic             w_accept;
  logic             w_repeat;

  assign w_sync   = ~r_sync[1];
  assign w_accept = (w_sync != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync    <= '1;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_press   <= (w_accept & w_sync) | w_repeat;
      r_release <= w_accept & ~w_sync;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  key_rpt_cnt_t r_rcnt;
  logic         r_rphase;
  key_rpt_cnt_t w_rlimit;

  // First repeat waits REPEAT_DELAY; later repeats use REPEAT_PERIOD.
  assign w_rlimit = r_rphase ? key_rpt_cnt_t'(REPEAT_PERIOD - 1)
                             : key_rpt_cnt_t'(REPEAT_DELAY - 1);
  assign w_repeat = r_level && !w_accept && (r_rcnt == w_rlimit);

  always_ff @(posedge i_clk) begin
    if (i_reset || !r_level || w_accept) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b0;
    end else if (w_repeat) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b1;
    end else begin
      r_rcnt <= r_rcnt + key_rpt_cnt_t'(1);
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

// File: rtl/key_debounce_edge.sv
// Debounced pushbutton bank with sticky press capture and masked, registered irq.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to enable press auto-repeat per key.
module key_debounce_edge
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY    = key_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = key_pkg::REPEAT_PERIOD,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] irq_mask,
  input  logic [NUM_KEYS-1:0] edge_clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] edge_cap,
  output logic                irq
);
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] r_edge_cap;
  logic                r_irq;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_chan #(
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_key_n  (key_n[g]),
      .o_level  (w_level[g]),
      .o_press  (w_press[g]),
      .o_release(w_release[g])
    );
  end

  // Set is OR-ed after the clear so a coincident press is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge_cap <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~edge_clr) | w_press;
      r_irq      <= |(r_edge_cap & irq_mask);
    end
  end

  assign key_level   = w_level;
  assign key_press   = w_press;
  assign key_release = w_release;
  assign edge_cap    = r_edge_cap;
  assign irq         = r_irq;
endmodule

// File: tb/tb_key_debounce_edge.sv
// Self-checking bench: directed steps plus random key activity against a window-based model.
module tb_key_debounce_edge;
  localparam int unsigned NK = 4;
  localparam int unsigned DB = 8;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] irq_mask = '0;
  logic [NK-1:0] edge_clr = '0;
  logic [NK-1:0] key_level, key_press, key_release, edge_cap;
  logic          irq;

  always #5 clk = ~clk;

  key_debounce_edge #(
    .NUM_KEYS       (NK),
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
`endif
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .irq_mask   (irq_mask),
    .edge_clr   (edge_clr),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .edge_cap   (edge_cap),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: history of pressed samples per edge; a key flips when the DB samples
  // that reached the comparator (two edges of synchroniser delay) all differ from its level.
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_level = '0, m_press = '0, m_release = '0, m_cap = '0;
  logic          m_irq = 1'b0;
  int            age[NK];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [NK-1:0] nlevel, npress, nrel, ncap;
    logic          nirq;
    logic          all_diff;
    int            n;
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (hist.size() > 0) hist[hist.size()-1] = '0;
      hist.push_back('0);
      m_level = '0; m_press = '0; m_release = '0; m_cap = '0; m_irq = 1'b0;
      for (int k = 0; k < NK; k++) age[k] = 0;
    end else begin
      hist.push_back(~key_n);
      n = hist.size();
      nlevel = m_level; npress = '0; nrel = '0;
      for (int k = 0; k < NK; k++) begin
        all_diff = (n >= int'(DB) + 2);
        if (all_diff)
          for (int i = n - int'(DB) - 2; i <= n - 3; i++)
            if (hist[i][k] == m_level[k]) all_diff = 1'b0;
        if (all_diff) begin
          nlevel[k] = ~m_level[k];
          if (nlevel[k]) begin npress[k] = 1'b1; age[k] = 0; end
          else nrel[k] = 1'b1;
        end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        else if (m_level[k]) begin
          age[k]++;
          if (age[k] >= int'(RD) && ((age[k] - int'(RD)) % int'(RP)) == 0) npress[k] = 1'b1;
        end
`endif
      end
      ncap = (m_cap & ~edge_clr) | m_press;
      nirq = |(m_cap & irq_mask);
      m_level = nlevel; m_press = npress; m_release = nrel; m_cap = ncap; m_irq = nirq;
    end
    while (hist.size() > 64) void'(hist.pop_front());
    #1;
    chk("level",   32'(key_level),   32'(m_level));
    chk("press",   32'(key_press),   32'(m_press));
    chk("release", 32'(key_release), 32'(m_release));
    chk("edge_cap", 32'(edge_cap),   32'(m_cap));
    chk("irq",     32'(irq),         32'(m_irq));
  endtask

  initial begin
    int pcount;
    for (int k = 0; k < NK; k++) age[k] = 0;

    // 1: reset with all keys held, then acceptance 10 edges after release
    reset = 1'b1; key_n = 4'b0000;
    repeat (3) step();
    chk("rst_level", 32'(key_level), 32'h0);
    chk("rst_irq",   32'(irq),       32'h0);
    reset = 1'b0;
    repeat (9) step();
    chk("t1_not_yet", 32'(key_level), 32'h0);
    step();
    chk("t1_level", 32'(key_level), 32'hF);
    chk("t1_press", 32'(key_press), 32'hF);
    key_n = 4'b1111;
    repeat (12) step();

    // 2: single key press with irq enabled
    irq_mask = 4'b0001; edge_clr = 4'b1111; step(); edge_clr = '0;
    key_n[0] = 1'b0; pcount = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (key_press[0]) pcount++;
      if (i == 8)  chk("t2_pre", 32'(key_level[0]), 32'h0);
      if (i == 9)  chk("t2_rise", 32'(key_level[0]), 32'h1);
      if (i == 11) chk("t2_irq", 32'(irq), 32'h1);
    end
    chk("t2_press_once", 32'(pcount), 32'h1);
    key_n[0] = 1'b1; repeat (12) step();

    // 3: bounce on key 1
    key_n[1] = 1'b0; repeat (5) step();
    key_n[1] = 1'b1; step();
    key_n[1] = 1'b0; pcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (key_press[1]) pcount++;
      if (i == 8) chk("t3_pre", 32'(key_level[1]), 32'h0);
      if (i == 9) chk("t3_rise", 32'(key_level[1]), 32'h1);
    end
    chk("t3_press_once", 32'(pcount), 32'h1);
    key_n[1] = 1'b1; repeat (12) step();

    // 4: clear coinciding with the press strobe, then a clear alone
    irq_mask = 4'b0100; edge_clr = 4'b1111; step(); edge_clr = '0;
    key_n[2] = 1'b0;
    for (int i = 0; i < 20 && !m_press[2]; i++) step();
    chk("t4_press", 32'(key_press[2]), 32'h1);
    edge_clr = 4'b0100; step(); edge_clr = '0;
    chk("t4_cap_kept", 32'(edge_cap[2]), 32'h1);
    repeat (3) step();
    edge_clr = 4'b0100; step(); edge_clr = '0;
    chk("t4_cap_clr", 32'(edge_cap[2]), 32'h0);
    chk("t4_irq_lag", 32'(irq), 32'h1);
    step();
    chk("t4_irq_drop", 32'(irq), 32'h0);

    // 5: release strobe, then reset partway through a debounce
    key_n[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 9) chk("t5_release", 32'(key_release[2]), 32'h1);
      chk("t5_no_press", 32'(key_press[2]), 32'h0);
    end
    key_n[3] = 1'b0; repeat (7) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_level", 32'(key_level), 32'h0);
    repeat (5) step();
    chk("t5_restart", 32'(key_level[3]), 32'h0);
    repeat (8) step();
    key_n[3] = 1'b1; repeat (12) step();

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    // 6: auto-repeat while held, stopped by release
    key_n[3] = 1'b0; repeat (62) step();
    key_n[3] = 1'b1; repeat (20) step();
`endif

    // Random key activity, masks, clears and occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, NK-1)] ^= 1'b1;
      if ((i % 50) == 0) irq_mask = NK'($urandom);
      edge_clr = ($urandom_range(0, 7) == 0) ? NK'($urandom) : '0;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; edge_clr = '0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
